// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, with a final sign-fix cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             Mul,
  input  logic             Div,
  input  logic             Unsigned,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned W1 = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] oper_q, oper_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [W1-1:0]    mul_sum;
  logic [PW-1:0]    mul_next;
  logic [W1-1:0]    div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [PW-1:0]    div_next;
  logic [PW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Operand magnitudes and one iteration of each datapath.
  always_comb begin
    a_neg     = !Unsigned && op_a[WIDTH-1];
    b_neg     = !Unsigned && op_b[WIDTH-1];
    a_abs     = a_neg ? WIDTH'(~op_a + WIDTH'(1)) : op_a;
    b_abs     = b_neg ? WIDTH'(~op_b + WIDTH'(1)) : op_b;
    mul_sum   = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, oper_q} : W1'(0));
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = acc_q[PW-1:WIDTH-1];
    div_ge    = div_shift >= {1'b0, oper_q};
    div_diff  = WIDTH'(div_shift - {1'b0, oper_q});
    div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    prod_fix  = neg_q ? PW'(~acc_q + PW'(1)) : acc_q;
    quo_fix   = neg_q ? WIDTH'(~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    rem_fix   = rem_neg_q ? WIDTH'(~acc_q[PW-1:WIDTH] + WIDTH'(1)) : acc_q[PW-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    oper_d    = oper_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // A start with an ambiguous op select is a no-op; it still suppresses moves.
          if (Mul ^ Div) begin
            is_div_d  = Div;
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            dz_d      = (op_b == '0);
            oper_d    = Div ? b_abs : a_abs;
            acc_d     = {WIDTH'(0), (Div ? a_abs : b_abs)};
            cnt_d     = CW'(WIDTH);
            busy_d    = 1'b1;
            state_d   = CALC;
          end
        end else begin
          if (mthi) hi_d = op_a;
          if (mtlo) lo_d = op_a;
        end
      end
      CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = dz_q ? '1 : quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      oper_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      oper_q    <= oper_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
